// File: rtl/cdma_multilink_if.sv
// Bus bundle for cdma_multilink: run control and user bits in, composite
// sample stream, strobes and recovered bits out.
interface cdma_multilink_if #(
    parameter int unsigned NUM_USERS = 4,
    parameter int unsigned SIG_W     = 16
);
    logic                 en;
    logic [NUM_USERS-1:0] data;
    logic [SIG_W-1:0]     signal;
    logic                 chip_tick;
    logic                 sym_start;
    logic [NUM_USERS-1:0] data_rec;
    logic                 rec_valid;

    modport master (
        output en, data,
        input  signal, chip_tick, sym_start, data_rec, rec_valid
    );

    modport slave (
        input  en, data,
        output signal, chip_tick, sym_start, data_rec, rec_valid
    );
endinterface

// File: rtl/cdma_multilink.sv
// Multi-user Walsh-coded CDMA link: spread, sum, and per-user correlate.
// Optional macro CDMA_NOISE_EN adds an LFSR-driven +/-1 chip noise term.
module cdma_multilink #(
    parameter int unsigned NUM_USERS = 4,
    parameter int unsigned CODE_LOG2 = 3,
    parameter int unsigned CHIP_DIV  = 50,
    parameter int unsigned SIG_W     = 16,
    parameter int unsigned SCALE_SH  = 10
) (
    input logic              CLOCK_50,
    input logic              RST_n,
    cdma_multilink_if.slave  bus
);

    localparam int unsigned CODE_LEN = 1 << CODE_LOG2;
    localparam int unsigned DIV_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int unsigned CV_W     = $clog2(2 * NUM_USERS + 2) + 2;
    localparam int unsigned ACC_W    = $clog2(CODE_LEN * (2 * NUM_USERS + 1)) + 2;

    localparam logic [SIG_W-1:0]        MID       = {1'b1, {(SIG_W-1){1'b0}}};
    localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CHIP_DIV - 1);
    localparam logic [CODE_LOG2-1:0]    CHIP_LAST = CODE_LOG2'(CODE_LEN - 1);
    localparam logic signed [CV_W-1:0]  CV_TWO    = CV_W'(2);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                   state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [CODE_LOG2-1:0]     chip_q, chip_d;
    logic [NUM_USERS-1:0]     tx_q, tx_d;
    logic [NUM_USERS-1:0]     rec_q, rec_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_USERS];
    logic signed [ACC_W-1:0]  acc_d [NUM_USERS];
    logic [SIG_W-1:0]         signal_q, signal_d;
    logic                     chip_tick_q, chip_tick_d;
    logic                     sym_start_q, sym_start_d;
    logic                     rec_valid_q, rec_valid_d;

    logic                     run_c;
    logic                     tick_c;
    logic [NUM_USERS-1:0]     bits_c;
    logic signed [CV_W-1:0]   chip_val_c;
    logic signed [ACC_W-1:0]  cv_acc_c;
    logic signed [SIG_W-1:0]  sig_off_c;
    logic signed [ACC_W-1:0]  term_c [NUM_USERS];
    logic signed [ACC_W-1:0]  sum_c  [NUM_USERS];

`ifdef CDMA_NOISE_EN
    localparam logic signed [CV_W-1:0] CV_ONE = CV_W'(1);
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb_c;
    assign lfsr_fb_c = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
`endif

    // Walsh row u+1 is negative where (u+1) & c has odd parity
    function automatic logic walsh_neg(input int unsigned u, input logic [CODE_LOG2-1:0] c);
        return ^(CODE_LOG2'(u + 1) & c);
    endfunction

    assign run_c     = (state_q == RUN) && bus.en;
    assign tick_c    = run_c && (div_q == DIV_LAST);
    assign bits_c    = (chip_q == '0) ? bus.data : tx_q;
    assign cv_acc_c  = ACC_W'(chip_val_c);
    assign sig_off_c = SIG_W'(chip_val_c) <<< SCALE_SH;

    // Composite chip value for the current chip index
    always_comb begin
        chip_val_c = '0;
        for (int unsigned u = 0; u < NUM_USERS; u++) begin
            chip_val_c = (bits_c[u] ^ walsh_neg(u, chip_q)) ? chip_val_c + CV_TWO
                                                            : chip_val_c - CV_TWO;
        end
`ifdef CDMA_NOISE_EN
        chip_val_c = lfsr_q[0] ? chip_val_c + CV_ONE : chip_val_c - CV_ONE;
`endif
    end

    always_comb begin
        for (int unsigned u = 0; u < NUM_USERS; u++) begin
            term_c[u] = walsh_neg(u, chip_q) ? -cv_acc_c : cv_acc_c;
            sum_c[u]  = acc_q[u] + term_c[u];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.en)  state_d = RUN;
            RUN:     if (!bus.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state; anything outside an enabled RUN clock parks it
    always_comb begin
        div_d       = div_q;
        chip_d      = chip_q;
        tx_d        = tx_q;
        rec_d       = rec_q;
        acc_d       = acc_q;
        signal_d    = signal_q;
        chip_tick_d = 1'b0;
        sym_start_d = 1'b0;
        rec_valid_d = 1'b0;
`ifdef CDMA_NOISE_EN
        lfsr_d      = lfsr_q;
`endif
        if (!run_c) begin
            div_d    = '0;
            chip_d   = '0;
            signal_d = MID;
            for (int unsigned u = 0; u < NUM_USERS; u++) acc_d[u] = '0;
        end else if (!tick_c) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d       = '0;
            chip_d      = chip_q + CODE_LOG2'(1);
            chip_tick_d = 1'b1;
            signal_d    = MID + $unsigned(sig_off_c);
`ifdef CDMA_NOISE_EN
            lfsr_d      = {lfsr_fb_c, lfsr_q[15:1]};
`endif
            if (chip_q == '0) begin
                tx_d        = bus.data;
                sym_start_d = 1'b1;
            end
            for (int unsigned u = 0; u < NUM_USERS; u++) begin
                if (chip_q == CHIP_LAST) begin
                    rec_d[u] = !sum_c[u][ACC_W-1] && (sum_c[u] != '0);
                    acc_d[u] = '0;
                end else begin
                    acc_d[u] = sum_c[u];
                end
            end
            if (chip_q == CHIP_LAST) rec_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            div_q       <= '0;
            chip_q      <= '0;
            tx_q        <= '0;
            rec_q       <= '0;
            signal_q    <= MID;
            chip_tick_q <= 1'b0;
            sym_start_q <= 1'b0;
            rec_valid_q <= 1'b0;
            for (int unsigned u = 0; u < NUM_USERS; u++) acc_q[u] <= '0;
        end else begin
            div_q       <= div_d;
            chip_q      <= chip_d;
            tx_q        <= tx_d;
            rec_q       <= rec_d;
            signal_q    <= signal_d;
            chip_tick_q <= chip_tick_d;
            sym_start_q <= sym_start_d;
            rec_valid_q <= rec_valid_d;
            for (int unsigned u = 0; u < NUM_USERS; u++) acc_q[u] <= acc_d[u];
        end
    end

`ifdef CDMA_NOISE_EN
    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`endif

    assign bus.signal    = signal_q;
    assign bus.chip_tick = chip_tick_q;
    assign bus.sym_start = sym_start_q;
    assign bus.data_rec  = rec_q;
    assign bus.rec_valid = rec_valid_q;

endmodule

// File: tb/tb_cdma_multilink.sv
// Scoreboard bench for cdma_multilink: stimulus schedules expected chips and
// symbol decisions; a negedge monitor pops them as the DUT strobes appear.
module tb_cdma_multilink;

    localparam int NU   = 4;
    localparam int CD   = 4;
    localparam int SW   = 16;
    localparam int CL   = 8;
    localparam int MIDV = 32768;

    typedef struct { int cyc; int sig; bit ss; } tick_t;
    typedef struct { int cyc; logic [NU-1:0] bits; } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    tick_t         tick_q[$];
    rec_t          rec_q[$];
    logic [NU-1:0] sym_bits[64];
    logic [NU-1:0] last_rec;

    cdma_multilink_if #(.NUM_USERS(NU), .SIG_W(SW)) bus();

    cdma_multilink #(.CHIP_DIV(CD)) dut (
        .CLOCK_50 (clk),
        .RST_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sum over users of 2*(+/-1 data)*(+/-1 Hadamard row u+1 entry)
    function automatic int chip_model(input logic [NU-1:0] b, input int c);
        int s;
        int w;
        s = 0;
        for (int u = 0; u < NU; u++) begin
            w = ($countones((u + 1) & c) % 2 == 0) ? 1 : -1;
            s += 2 * (b[u] ? 1 : -1) * w;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        tick_t te;
        rec_t  re;
        int    d;
        if (rst_n) begin
            if (bus.chip_tick) begin
                if (tick_q.size() == 0) begin
                    check_int("unexpected_chip_tick", 1, 0);
                end else begin
                    te = tick_q.pop_front();
                    check_int("tick_cycle", cyc, te.cyc);
                    check_int("tick_sym_start", int'(bus.sym_start), int'(te.ss));
`ifdef CDMA_NOISE_EN
                    d = int'(bus.signal) - te.sig;
                    if (d < 0) d = -d;
                    check_int("tick_noise_dev", d, 1024);
`else
                    d = int'(bus.signal);
                    check_int("tick_signal", d, te.sig);
`endif
                end
            end else if (bus.sym_start) begin
                check_int("sym_start_without_tick", 1, 0);
            end
            if (bus.rec_valid) begin
                if (rec_q.size() == 0) begin
                    check_int("unexpected_rec_valid", 1, 0);
                end else begin
                    re = rec_q.pop_front();
                    check_int("rec_cycle", cyc, re.cyc);
                    check_int("rec_bits", int'(bus.data_rec), int'(re.bits));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_signal"},    int'(bus.signal), MIDV);
        check_int({tag, "_data_rec"},  int'(bus.data_rec), 0);
        check_int({tag, "_rec_valid"}, int'(bus.rec_valid), 0);
        check_int({tag, "_chip_tick"}, int'(bus.chip_tick), 0);
        check_int({tag, "_sym_start"}, int'(bus.sym_start), 0);
    endtask

    // Run from IDLE; stop after tick stop_tick (or all symbols), then drop en or reset
    task automatic run_symbols(input int nsym, input bit toggle, input int stop_tick, input bit stop_rst);
        int    e0;
        int    total;
        int    k;
        bit    sample;
        tick_t te;
        rec_t  re;
        e0    = cyc;
        total = (stop_tick >= 0) ? stop_tick + 1 : nsym * CL;
        for (int t = 0; t < total; t++) begin
            te.cyc = e0 + 1 + CD * (t + 1);
            te.sig = MIDV + 1024 * chip_model(sym_bits[t / CL], t % CL);
            te.ss  = (t % CL == 0);
            tick_q.push_back(te);
            if (t % CL == CL - 1) begin
                re.cyc  = te.cyc;
                re.bits = sym_bits[t / CL];
                rec_q.push_back(re);
            end
        end
        for (int n = 1; n <= 1 + CD * total; n++) begin
            k      = (n < 2) ? 0 : (n - 2) / CD;
            sample = (n > 1) && ((n - 1) % CD == 0) && (k % CL == 0);
            if (toggle && !sample) bus.data = NU'($urandom);
            else                   bus.data = sym_bits[k / CL];
            bus.en = 1'b1;
            @(posedge clk); #1;
        end
        if (total >= CL) last_rec = sym_bits[total / CL - 1];
        if (stop_rst) begin
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midsym_reset");
            tick_q.delete();
            rec_q.delete();
            last_rec = '0;
            bus.en   = 1'b0;
            rst_n    = 1'b1;
            @(posedge clk); #1;
            check_int("post_reset_signal", int'(bus.signal), MIDV);
        end else begin
            bus.en = 1'b0;
            @(posedge clk); #1;
            check_int("idle_signal", int'(bus.signal), MIDV);
            check_int("idle_data_rec", int'(bus.data_rec), int'(last_rec));
        end
    endtask

    task automatic randomize_bits(input int nsym);
        for (int i = 0; i < nsym; i++) sym_bits[i] = NU'($urandom);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.data = 4'b1111;
        last_rec = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // all-ones user data straight out of reset
        sym_bits[0] = 4'b1111;
        run_symbols(1, 1'b0, -1, 1'b0);

        // constant pattern for three back-to-back symbols
        for (int i = 0; i < 3; i++) sym_bits[i] = 4'b0101;
        run_symbols(3, 1'b0, -1, 1'b0);

        // data wiggles between sample edges
        randomize_bits(4);
        run_symbols(4, 1'b1, -1, 1'b0);

        // abort at chip 5 of the second symbol, then restart
        randomize_bits(2);
        run_symbols(2, 1'b1, CL + 5, 1'b0);
        randomize_bits(1);
        run_symbols(1, 1'b0, -1, 1'b0);

        // asynchronous reset in the middle of the second symbol
        randomize_bits(2);
        run_symbols(2, 1'b1, CL + 2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        randomize_bits(1);
        run_symbols(1, 1'b0, -1, 1'b0);

        // long random run
        randomize_bits(64);
        run_symbols(64, 1'b1, -1, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        check_int("pending_ticks", tick_q.size(), 0);
        check_int("pending_recs", rec_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdma_multilink.md
# cdma_multilink

Parametrised multi-user CDMA link: spreads one data bit per user per symbol with orthogonal Walsh codes, sums the users into one composite chip stream, and despreads every user back to a recovered bit on a per-symbol correlator. It replaces the fixed two-receiver signal generator that feeds the oscilloscope. It drives a 16-bit unsigned mid-scale sample bus (`signal`) straight into the oscilloscope's `signal` input, and exposes recovered bits for LEDs and the bench.

## Interface
Parameters:
- NUM_USERS, 4: number of users; must be 1..CODE_LEN-1.
- CODE_LOG2, 3: CODE_LEN = 2^CODE_LOG2 chips per symbol.
- CHIP_DIV, 50: CLOCK_50 cycles per chip (≥2).
- SIG_W, 16: width of `signal`.
- SCALE_SH, 10: left shift applied to the chip value for display.

Ports:
- CLOCK_50, in, 1: system clock, all logic on rising edge.
- RST_n, in, 1: asynchronous active-low reset.
- en, in, 1: run enable.
- data, in, NUM_USERS: user bits; bit u belongs to user u; 1 maps to +1, 0 maps to −1.
- signal, out, SIG_W: composite chip sample, offset binary.
- chip_tick, out, 1: one-clock pulse per chip update.
- sym_start, out, 1: one-clock pulse when `data` is sampled.
- data_rec, out, NUM_USERS: recovered bits, held between symbols.
- rec_valid, out, 1: one-clock pulse when `data_rec` updates.

## Operation
- Code for user u is Hadamard row u+1: w_u[c] = +1 if popcount((u+1) & c) is even, else −1. Row 0 (DC) is never used.
- FSM has two states:
  - IDLE: counters at 0, accumulators at 0, `signal` = 2^(SIG_W−1). Moves to RUN when en=1.
  - RUN: moves back to IDLE on the first clock with en=0.
- Chip divider: `div` counts 0..CHIP_DIV−1 in RUN. A tick is the clock where div = CHIP_DIV−1. The chip index c (CODE_LOG2 bits) advances on each tick and wraps from CODE_LEN−1 to 0.
- First tick of a symbol (c = 0):
  - `data` is latched into tx_bits.
  - `sym_start` pulses.
  - The latched value is used for that chip.
- On every tick, the chip value is chip_val = Σ_u 2·b_u·w_u[c], plus the noise term when compiled in (see Configuration).
  - chip_val is signed; width ≥ clog2(2·NUM_USERS+2)+1.
  - `signal` is registered as 2^(SIG_W−1) + (chip_val <<< SCALE_SH), truncated to SIG_W bits. Parameters must be chosen so this never overflows.
- Correlator, per user, on each tick: acc_u += chip_val·w_u[c]. acc width ≥ clog2(CODE_LEN·(2·NUM_USERS+1))+2.
- On the tick with c = CODE_LEN−1:
  - data_rec[u] = (acc_u + final term > 0).
  - Every acc_u is cleared.
  - `rec_valid` pulses.
- Noise-free, each correlation equals 2·CODE_LEN·b_u exactly.
- en=0 mid-symbol: the symbol is aborted. No `rec_valid`. `data_rec` keeps its old value. Restart begins at c = 0 with div = 0.

## Timing
- Reset values: signal = 2^(SIG_W−1), data_rec = 0, rec_valid = 0, chip_tick = 0, sym_start = 0. Internally, FSM = IDLE, div = 0, c = 0, and accumulators and LFSR are at their seeds.
- After en rises, the first tick is on the CHIP_DIVth RUN clock.
- `chip_tick`, `sym_start`, and `signal` update on the tick edge and are visible the following cycle.
- `data` is sampled only on the sym_start tick edge. Changes at other times have no effect.
- Latency: `data_rec` and `rec_valid` appear (CODE_LEN−1)·CHIP_DIV clocks after the `sym_start` edge of the same symbol.
- Back-to-back symbols run with no gap. Symbol period is CODE_LEN·CHIP_DIV clocks.
- RST_n assertion at any point forces reset values immediately (asynchronous). Release is synchronous in effect: the first RUN clock follows the first edge after release.

## Configuration
- CDMA_NOISE_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) steps on each tick.
  - Its LSB adds +1 (LSB = 1) or −1 (LSB = 0) to chip_val before display and correlation.
  - Decisions remain exact because |noise correlation| ≤ CODE_LEN < 2·CODE_LEN.
- CDMA_NOISE_EN undefined: noise term is 0 and no LFSR is built.

## Test plan
All scenarios use defaults except CHIP_DIV = 4.
- Reset with en=1 and data = 4'b1111. Release -> first tick gives `signal` = 40960 (chip 0, sum +8). Chip 1 gives 32768. After 28 clocks from sym_start, data_rec = 4'b1111 and rec_valid pulses for 1 clock.
- data = 4'b0101 held for 3 symbols -> data_rec = 4'b0101 after each symbol. Exactly three rec_valid pulses, spaced 32 clocks apart.
- data toggled on non-c=0 ticks during a symbol -> data_rec reflects only the value present on the sym_start edge.
- en dropped at c = 5 -> `signal` returns to 32768 next clock, no rec_valid, data_rec unchanged. en re-raised -> sym_start on its 4th clock.
- RST_n pulsed low mid-symbol -> all outputs at reset values within the same cycle, no stale rec_valid afterwards.
- CDMA_NOISE_EN defined, 64 random symbols -> data_rec matches the transmitted bits on every symbol, and `signal` deviates from the noise-free value by exactly ±1024.
